// File: rtl/demux_stream_1xn.sv
// Registered 1-to-N stream demultiplexer with a one-entry holding slot per output channel.
// Words are steered by in_sel or copied to every channel by in_bcast; out-of-range selects are sunk and counted.
module demux_stream_1xn #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_bcast,
    output logic [N-1:0]     out_valid,
    input  logic [N-1:0]     out_ready,
    output logic [N*W-1:0]   out_data,
    output logic             sel_err,
    output logic [7:0]       err_cnt
);

    typedef enum logic {EMPTY, FULL} chan_state_t;

    logic [N-1:0] slot_free;
    logic [N-1:0] sel_match;
    logic [N-1:0] load;
    logic         in_range;
    logic         accept;
    logic         drop;
    logic         sel_err_reg;
    logic [7:0]   err_cnt_reg;

    assign in_range = |sel_match;

    // Broadcast needs every slot at once so a word is never delivered partially.
    always_comb begin
        in_ready = 1'b1;
        if (in_bcast)
            in_ready = &slot_free;
        else if (in_range)
            in_ready = |(sel_match & slot_free);
    end

    assign accept = in_valid & in_ready;
    assign drop   = accept & ~in_bcast & ~in_range;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            chan_state_t state_reg, state_next;
            logic [W-1:0] data_reg;

            assign sel_match[gi] = (32'(in_sel) == gi);
            assign load[gi]      = accept & (in_bcast | sel_match[gi]);
            assign slot_free[gi] = (state_reg == EMPTY) | out_ready[gi];

            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    EMPTY: if (load[gi]) state_next = FULL;
                    FULL:  if (!load[gi] && out_ready[gi]) state_next = EMPTY;
                    default: state_next = EMPTY;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= EMPTY;
                    data_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    if (load[gi])
                        data_reg <= in_data;
                end
            end

            assign out_valid[gi]         = (state_reg == FULL);
            assign out_data[gi*W +: W]   = data_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_reg <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            sel_err_reg <= drop;
            if (drop && err_cnt_reg != 8'hFF)
                err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign sel_err = sel_err_reg;
    assign err_cnt = err_cnt_reg;

endmodule
